// File: rtl/spi_interface.sv
// Mode-3 SPI master for one 16-bit ADC128S022-style frame: 3-bit channel out, 12-bit result in.
// A frame spans 33*CLK_DIV clk cycles from start to valid. start is ignored while busy; there is no other backpressure.
module spi_interface #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  channel,
    input  logic        dout,
    output logic        sclk,
    output logic        din,
    output logic        chipsel,
    output logic [3:0]  count,
    output logic [11:0] data,
    output logic        valid,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    state_t         state_q;
    logic [DW-1:0]  div_q;
    logic           sclk_q;
    logic           din_q;
    logic           cs_q;
    logic [3:0]     count_q;
    logic [11:0]    data_q;
    logic           valid_q;
    logic           busy_q;
    logic [11:0]    shreg_q;
    logic [14:0]    tx_q;

    logic           tick;
    logic [15:0]    ctrl;

    assign tick = (div_q == DW'(CLK_DIV - 1));
    assign ctrl = {2'b00, channel, 11'b0};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            sclk_q  <= 1'b1;
            din_q   <= 1'b0;
            cs_q    <= 1'b1;
            count_q <= 4'd0;
            data_q  <= 12'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            shreg_q <= 12'd0;
            tx_q    <= 15'd0;
        end else begin
            valid_q <= 1'b0;
            if (state_q == IDLE || tick) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + DW'(1);
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        din_q   <= ctrl[15];
                        tx_q    <= ctrl[14:0];
                        cs_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        count_q <= 4'd0;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        sclk_q  <= 1'b0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (!sclk_q) begin
                            // Only the last 12 samples survive; the 4 leading bits fall off the top.
                            sclk_q  <= 1'b1;
                            shreg_q <= {shreg_q[10:0], dout};
                            if (count_q == 4'd15) begin
                                state_q <= HOLD;
                            end
                        end else begin
                            sclk_q  <= 1'b0;
                            count_q <= count_q + 4'd1;
                            din_q   <= tx_q[14];
                            tx_q    <= {tx_q[13:0], 1'b0};
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        cs_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        count_q <= 4'd0;
                        data_q  <= shreg_q;
                        valid_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sclk    = sclk_q;
    assign din     = din_q;
    assign chipsel = cs_q;
    assign count   = count_q;
    assign data    = data_q;
    assign valid   = valid_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_spi_interface.sv
// Bench for spi_interface: directed frames on CLK_DIV=4 and CLK_DIV=1 instances with a serial ADC model.
// Expected results are queued at start and compared when valid pulses.
module tb_spi_interface;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, sel, dout;
    logic [2:0]  channel;
    logic        start4, start1;
    logic        sclk4, din4, cs4, valid4, busy4;
    logic        sclk1, din1, cs1, valid1, busy1;
    logic [3:0]  count4, count1;
    logic [11:0] data4, data1;

    assign start4 = start & ~sel;
    assign start1 = start & sel;

    spi_interface #(.CLK_DIV(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .channel(channel), .dout(dout),
        .sclk(sclk4), .din(din4), .chipsel(cs4), .count(count4),
        .data(data4), .valid(valid4), .busy(busy4)
    );

    spi_interface #(.CLK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .channel(channel), .dout(dout),
        .sclk(sclk1), .din(din1), .chipsel(cs1), .count(count1),
        .data(data1), .valid(valid1), .busy(busy1)
    );

    logic        m_sclk, m_din, m_cs, m_valid, m_busy;
    logic [3:0]  m_count;
    logic [11:0] m_data;
    assign m_sclk  = sel ? sclk1  : sclk4;
    assign m_din   = sel ? din1   : din4;
    assign m_cs    = sel ? cs1    : cs4;
    assign m_valid = sel ? valid1 : valid4;
    assign m_busy  = sel ? busy1  : busy4;
    assign m_count = sel ? count1 : count4;
    assign m_data  = sel ? data1  : data4;

    // ADC model: presents the next word bit on every SCLK fall while selected.
    logic [15:0] adc_word;
    int          adc_idx = 0;
    always @(negedge m_cs) adc_idx = 0;
    always @(negedge m_sclk) begin
        if (!m_cs && adc_idx < 16) begin
            dout = adc_word[15 - adc_idx];
            adc_idx++;
        end
    end

    int passes = 0;
    int fails  = 0;
    int total  = 0;
    logic [11:0] exp_data[$];
    logic [15:0] exp_ctrl[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_sclk"},  32'(m_sclk),  32'd1);
        check({tag, "_cs"},    32'(m_cs),    32'd1);
        check({tag, "_din"},   32'(m_din),   32'd0);
        check({tag, "_count"}, 32'(m_count), 32'd0);
        check({tag, "_busy"},  32'(m_busy),  32'd0);
        check({tag, "_valid"}, 32'(m_valid), 32'd0);
        check({tag, "_data"},  32'(m_data),  32'd0);
    endtask

    // Called at a negedge; returns at the negedge where valid is seen (or the bound expires).
    task automatic run_frame(input logic [2:0] ch, input logic [2:0] next_ch, input logic [15:0] adc,
                             input int d, input bit keep_start, input bit mid_start);
        logic [15:0] ctrl, rx_din, ectrl;
        logic [11:0] edata;
        logic        prev_sclk, prev_din;
        int t, rises, last_rise, first_fall, cnt_err, per_err, din_err, prot_err;
        bit got;
        ctrl = {2'b00, ch, 11'b0};
        exp_data.push_back(adc[11:0]);
        exp_ctrl.push_back(ctrl);
        start = 1'b1;
        channel = ch;
        adc_word = adc;
        @(posedge clk);
        @(negedge clk);
        if (!keep_start) start = 1'b0;
        channel = keep_start ? next_ch : ~ch;
        check("accept_cs",    32'(m_cs),    32'd0);
        check("accept_busy",  32'(m_busy),  32'd1);
        check("accept_valid", 32'(m_valid), 32'd0);
        check("accept_count", 32'(m_count), 32'd0);
        check("accept_din",   32'(m_din),   32'(ctrl[15]));
        t = 0; rises = 0; last_rise = 0; first_fall = -1;
        cnt_err = 0; per_err = 0; din_err = 0; prot_err = 0; got = 0;
        rx_din = 16'h0;
        prev_sclk = m_sclk;
        prev_din = m_din;
        while (!got && t < 40 * d + 8) begin
            @(negedge clk);
            t++;
            if (mid_start && t == 10 * d) start = 1'b1;
            if (mid_start && t == 10 * d + 1) start = 1'b0;
            if (prev_sclk && !m_sclk && first_fall < 0) first_fall = t;
            if (!prev_sclk && m_sclk) begin
                if (rises < 16) rx_din[15 - rises] = m_din;
                if (m_count !== 4'(rises)) cnt_err++;
                if (rises > 0 && t - last_rise != 2 * d) per_err++;
                last_rise = t;
                rises++;
            end
            if (m_din !== prev_din && !(prev_sclk && !m_sclk)) din_err++;
            if (m_cs && !m_sclk) prot_err++;
            prev_sclk = m_sclk;
            prev_din = m_din;
            if (m_valid) got = 1;
        end
        check("valid_seen",  32'(got),        32'd1);
        check("valid_time",  32'(t),          32'(33 * d));
        check("first_fall",  32'(first_fall), 32'(d));
        check("rise_count",  32'(rises),      32'd16);
        check("count_seq",   32'(cnt_err),    32'd0);
        check("sclk_period", 32'(per_err),    32'd0);
        check("din_stable",  32'(din_err),    32'd0);
        check("sclk_idle",   32'(prot_err),   32'd0);
        check("end_cs",      32'(m_cs),       32'd1);
        check("end_busy",    32'(m_busy),     32'd0);
        check("end_count",   32'(m_count),    32'd0);
        if (got && exp_data.size() > 0) begin
            edata = exp_data.pop_front();
            ectrl = exp_ctrl.pop_front();
            check("data",     32'(m_data), 32'(edata));
            check("din_word", 32'(rx_din), 32'(ectrl));
        end
    endtask

    initial begin
        int t, vcnt;
        reset = 1'b1; start = 1'b0; sel = 1'b0; channel = 3'd0; dout = 1'b0; adc_word = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_idle("reset4");
        sel = 1'b1;
        #1;
        check_idle("reset1");
        sel = 1'b0;
        @(negedge clk);

        run_frame(3'd5, 3'd0, 16'h0ABC, 4, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        run_frame(3'd3, 3'd6, 16'hA5A5, 4, 1'b1, 1'b0);
        run_frame(3'd6, 3'd0, 16'hF123, 4, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        run_frame(3'd1, 3'd0, 16'h0777, 4, 1'b0, 1'b1);
        repeat (3) @(negedge clk);

        // Abort a frame at count 7 with reset.
        start = 1'b1; channel = 3'd2; adc_word = 16'h0FFF;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (m_count != 4'd7 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("midrst_reach", 32'(m_count), 32'd7);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle("midrst");
        reset = 1'b0;
        vcnt = 0;
        repeat (160) begin
            @(negedge clk);
            if (m_valid) vcnt++;
        end
        check("midrst_novalid", 32'(vcnt), 32'd0);
        run_frame(3'd7, 3'd0, 16'h0C3A, 4, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        sel = 1'b1;
        @(negedge clk);
        run_frame(3'd5, 3'd0, 16'h0ABC, 1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        run_frame(3'd2, 3'd0, 16'h3456, 1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
